count_sequencer: RTL and testbench

Controller that sequences a 4-bit binary up-counter datapath on behalf of a requester:
- accepts a start command with a terminal value and mode, then clears, runs, pauses and stops the counter;
- reports completion with a one-cycle done pulse;
- optionally tallies completed passes.

It sits between control logic and the counter datapath, replacing free-running counting with commanded, bounded runs.

---
 rtl/count_sequencer_pkg.sv | 13 +
 rtl/count_sequencer_core.sv | 26 ++
 rtl/count_sequencer.sv | 130 +++++++++++++
 tb/tb_count_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/count_sequencer_pkg.sv
// rtl/count_sequencer_pkg.sv - shared state encoding and constants for count_sequencer
package count_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int PASS_MAX      = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/count_sequencer_core.sv
// rtl/count_sequencer_core.sv - count_core: WIDTH-bit up-counter, clr has priority over en
module count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - commanded bounded runs of count_core; pass tally built only with COUNT_SEQ_PASS_CNT_EN
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] term,
  input  logic             reload,
  input  logic             pause,
  input  logic             stop,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             aborted,
  output logic [3:0]       passes
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] term_q;
  logic             reload_q;
  logic             done_q;
  logic             aborted_q;
  logic             clr;
  logic             en;
  logic             accept;
  logic             complete;
  logic             abort;

  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    en       = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr = 1'b1;
        if (stop) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // stop outranks a completion landing on the same edge
        if (stop) begin
          abort   = 1'b1;
          clr     = 1'b1;
          state_d = IDLE;
        end else if (!pause) begin
          if (count == term_q) begin
            complete = 1'b1;
            if (reload_q) begin
              clr = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      term_q    <= '0;
      reload_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= complete;
      aborted_q <= abort;
      if (accept) begin
        term_q   <= term;
        reload_q <= reload;
      end
    end
  end

  count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .en     (en),
    .count  (count)
  );

`ifdef COUNT_SEQ_PASS_CNT_EN
  logic [3:0] passes_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      passes_q <= 4'd0;
    end else if (accept) begin
      passes_q <= 4'd0;
    end else if (complete && passes_q != 4'(PASS_MAX)) begin
      passes_q <= passes_q + 4'd1;
    end
  end

  assign passes = passes_q;
`else
  assign passes = 4'd0;
`endif

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - vector-table bench for count_sequencer; pass tally expectations follow COUNT_SEQ_PASS_CNT_EN
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] term;
  logic       reload;
  logic       pause;
  logic       stop;
  logic       ready;
  logic       busy;
  logic [3:0] count;
  logic       done;
  logic       aborted;
  logic [3:0] passes;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .term   (term),
    .reload (reload),
    .pause  (pause),
    .stop   (stop),
    .ready  (ready),
    .busy   (busy),
    .count  (count),
    .done   (done),
    .aborted(aborted),
    .passes (passes)
  );

  typedef struct {
    string      tag;
    logic       s;
    logic [3:0] t;
    logic       r;
    logic       p;
    logic       st;
    logic [3:0] e_count;
    logic       e_done;
    logic       e_ready;
    logic       e_busy;
    logic       e_aborted;
    logic       chk_p;
    logic [3:0] e_passes;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [3:0] pexp(int n);
    logic [3:0] v;
    v = 4'(n);
`ifndef COUNT_SEQ_PASS_CNT_EN
    v = 4'd0;
`endif
    return v;
  endfunction

  function automatic void add(string tag, logic s, logic [3:0] t, logic r, logic p, logic st,
                              logic [3:0] ec, logic ed, logic er, logic eb, logic ea,
                              logic cp, logic [3:0] ep);
    vec_t v;
    v.tag = tag; v.s = s; v.t = t; v.r = r; v.p = p; v.st = st;
    v.e_count = ec; v.e_done = ed; v.e_ready = er; v.e_busy = eb; v.e_aborted = ea;
    v.chk_p = cp; v.e_passes = ep;
    vecs.push_back(v);
  endfunction

  // busy-state row (CLEAR or RUN after the edge)
  function automatic void addb(string tag, logic s, logic [3:0] t, logic r, logic p,
                               logic [3:0] ec, logic ed, logic cp, logic [3:0] ep);
    add(tag, s, t, r, p, 1'b0, ec, ed, 1'b0, 1'b1, 1'b0, cp, ep);
  endfunction

  // idle-state row (IDLE after the edge)
  function automatic void addi(string tag, logic s, logic [3:0] t, logic r, logic st,
                               logic [3:0] ec, logic ed, logic ea, logic cp, logic [3:0] ep);
    add(tag, s, t, r, 1'b0, st, ec, ed, 1'b1, 1'b0, ea, cp, ep);
  endfunction

  task automatic check_row();
    vec_t e;
    e = sb.pop_front();
    tests++;
    if (count !== e.e_count || done !== e.e_done || ready !== e.e_ready ||
        busy !== e.e_busy || aborted !== e.e_aborted ||
        (e.chk_p && passes !== e.e_passes)) begin
      fails++;
      $display("FAIL %s: got count=%0d done=%0b ready=%0b busy=%0b aborted=%0b passes=%0d; expected count=%0d done=%0b ready=%0b busy=%0b aborted=%0b passes=%0d(chk=%0b)",
               e.tag, count, done, ready, busy, aborted, passes,
               e.e_count, e.e_done, e.e_ready, e.e_busy, e.e_aborted, e.e_passes, e.chk_p);
    end
  endtask

  task automatic apply(vec_t v);
    start  = v.s;
    term   = v.t;
    reload = v.r;
    pause  = v.p;
    stop   = v.st;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_row();
  endtask

  task automatic check_reset_vals(string tag);
    tests++;
    if (ready !== 1'b1 || busy !== 1'b0 || count !== 4'd0 || done !== 1'b0 ||
        aborted !== 1'b0 || passes !== 4'd0) begin
      fails++;
      $display("FAIL %s: got ready=%0b busy=%0b count=%0d done=%0b aborted=%0b passes=%0d; expected 1 0 0 0 0 0",
               tag, ready, busy, count, done, aborted, passes);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; term = 4'd0; reload = 1'b0; pause = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset_state");
    reset_n = 1'b1;

    // one-shot term=5, then back-to-back start in the done cycle
    addb("os5_start", 1, 5, 0, 0, 0, 0, 1, pexp(0));
    for (int n = 0; n <= 5; n++) addb("os5_run", 0, 5, 0, 0, 4'(n), 0, 0, 0);
    addi("os5_done", 0, 5, 0, 0, 5, 1, 0, 1, pexp(1));
    addb("b2b_start", 1, 2, 0, 0, 5, 0, 1, pexp(0));
    for (int n = 0; n <= 2; n++) addb("b2b_run", 0, 2, 0, 0, 4'(n), 0, 0, 0);
    addi("b2b_done", 0, 2, 0, 0, 2, 1, 0, 0, 0);
    addi("idle_stop", 0, 2, 0, 1, 2, 0, 0, 0, 0);

    // pause for 3 cycles at count=2 delays done to 9 cycles after start
    addb("pause_start", 1, 4, 0, 0, 2, 0, 0, 0);
    for (int n = 0; n <= 2; n++) addb("pause_run", 0, 4, 0, 0, 4'(n), 0, 0, 0);
    for (int k = 0; k < 3; k++) addb("pause_hold", (k == 1), 9, 1, 1, 2, 0, 0, 0);
    addb("pause_run3", 0, 4, 0, 0, 3, 0, 0, 0);
    addb("pause_run4", 0, 4, 0, 0, 4, 0, 0, 0);
    addi("pause_done", 0, 4, 0, 0, 4, 1, 0, 0, 0);

    // stop collides with completion in auto-reload term=2
    addb("col_start", 1, 2, 1, 0, 4, 0, 0, 0);
    for (int n = 0; n <= 2; n++) addb("col_run", 0, 2, 1, 0, 4'(n), 0, 0, 0);
    addb("col_pass1", 0, 2, 1, 0, 0, 1, 1, pexp(1));
    addb("col_run", 0, 2, 1, 0, 1, 0, 0, 0);
    addb("col_run", 0, 2, 1, 0, 2, 0, 0, 0);
    addi("col_stop", 0, 2, 1, 1, 0, 0, 1, 1, pexp(1));
    addi("col_after", 0, 2, 1, 0, 0, 0, 0, 1, pexp(1));

    // term=0 auto-reload; mid-run start with term=7 ignored
    addb("t0_start", 1, 0, 1, 0, 0, 0, 0, 0);
    addb("t0_run0", 0, 0, 1, 0, 0, 0, 0, 0);
    addb("t0_pass1", 0, 0, 1, 0, 0, 1, 1, pexp(1));
    addb("t0_ignstart", 1, 7, 0, 0, 0, 1, 0, 0);
    addb("t0_pass3", 0, 7, 0, 0, 0, 1, 1, pexp(3));
    addi("t0_stop", 0, 0, 0, 1, 0, 0, 1, 0, 0);

    // start and stop together in IDLE; one-shot term=15
    add("t15_startstop", 1, 15, 0, 0, 1, 0, 0, 0, 1, 0, 1, pexp(0));
    for (int n = 0; n <= 15; n++) addb("t15_run", 0, 15, 0, 0, 4'(n), 0, 0, 0);
    addi("t15_done", 0, 15, 0, 0, 15, 1, 0, 1, pexp(1));
    addi("t15_hold", 0, 15, 0, 0, 15, 0, 0, 0, 0);

    // auto-reload term=3 for 20 passes; tally saturates at 15
    addb("ar3_start", 1, 3, 1, 0, 15, 0, 0, 0);
    for (int i = 1; i <= 81; i++)
      addb("ar3_run", 0, 3, 1, 0, 4'((i - 1) % 4), (i >= 5 && (i - 1) % 4 == 0),
           (i == 57 || i == 81), (i == 57) ? pexp(14) : pexp(15));
    addi("ar3_stop", 0, 3, 1, 1, 0, 0, 1, 1, pexp(15));

    // run up to count=6 ahead of the asynchronous reset
    addb("rst_start", 1, 9, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n <= 6; n++) addb("rst_run", 0, 9, 0, 0, 4'(n), 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("reset_midrun");
    @(posedge clk);
    #1;
    check_reset_vals("reset_held");
    reset_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("reset_release_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
